// File: rtl/fpmult_seq_if.sv
// Issue/result interface of the sequential IEEE-754 multiplier.
// Handshake: a transfer occurs on a rising clk edge where valid and ready are both high; the sender keeps its payload stable while valid is high and ready is low.
interface fpmult_seq_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] m;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rm, out_ready,
    input  in_ready, out_valid, m, flags
  );

  modport slave (
    input  in_valid, a, b, rm, out_ready,
    output in_ready, out_valid, m, flags
  );
endinterface

// File: rtl/fpmult_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product, one multiplier bit per cycle,
// then a single normalise/round/specials cycle. Subnormal operands are treated as zero.
module fpmult_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic        clk,
  input  logic        reset,
  fpmult_seq_if.slave bus,
  output logic [1:0]  state_dbg
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int P     = FRAC_W + 1;
  localparam int ACC_W = 2 * P;
  localparam int CNT_W = $clog2(P);
  localparam int E_W   = EXP_W + 2;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(P - 1);
  localparam logic signed [E_W-1:0] BIAS     = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MAX    = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO   = '0;
  localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             rm_q, rm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     m_q, m_d;
  logic [3:0]       flags_q, flags_d;

  logic              sign;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [P-1:0]      sig_a, sig_b;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  always_comb begin
    sign   = a_q[W-1] ^ b_q[W-1];
    exp_a  = a_q[W-2 -: EXP_W];
    exp_b  = b_q[W-2 -: EXP_W];
    frac_a = a_q[FRAC_W-1:0];
    frac_b = b_q[FRAC_W-1:0];
    a_zero = (exp_a == '0);
    b_zero = (exp_b == '0);
    a_inf  = (&exp_a) & ~(|frac_a);
    b_inf  = (&exp_b) & ~(|frac_b);
    a_nan  = (&exp_a) & (|frac_a);
    b_nan  = (&exp_b) & (|frac_b);
    a_snan = a_nan & ~frac_a[FRAC_W-1];
    b_snan = b_nan & ~frac_b[FRAC_W-1];
    // A zero exponent drops the hidden bit entirely, so subnormals multiply as zero.
    sig_a  = a_zero ? '0 : {1'b1, frac_a};
    sig_b  = b_zero ? '0 : {1'b1, frac_b};
  end

  logic                  msb;
  logic [ACC_W-2:0]      norm;
  logic [FRAC_W-1:0]     frac_t;
  logic                  guard, sticky, round_up;
  logic [FRAC_W:0]       frac_r;
  logic signed [E_W-1:0] e_pre, e_rnd;
  logic [W-1:0]          m_res;
  logic [3:0]            flags_res;

  always_comb begin
    msb      = acc_q[ACC_W-1];
    norm     = msb ? acc_q[ACC_W-2:0] : {acc_q[ACC_W-3:0], 1'b0};
    frac_t   = norm[ACC_W-2 -: FRAC_W];
    guard    = norm[FRAC_W];
    sticky   = |norm[FRAC_W-1:0];
    round_up = ~rm_q & guard & (sticky | frac_t[0]);
    frac_r   = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
    e_pre    = E_W'(exp_a) + E_W'(exp_b) - BIAS + E_W'(msb);
    // A carry out of the rounded fraction leaves all-zero fraction bits and bumps the exponent.
    e_rnd    = e_pre + E_W'(frac_r[FRAC_W]);

    m_res     = {sign, e_rnd[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    flags_res = {3'b000, guard | sticky};
    if (a_nan | b_nan) begin
      m_res     = QNAN;
      flags_res = {a_snan | b_snan, 3'b000};
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      m_res     = QNAN;
      flags_res = 4'b1000;
    end else if (a_inf | b_inf) begin
      m_res     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_res = 4'b0000;
    end else if (a_zero | b_zero) begin
      m_res     = {sign, {(W-1){1'b0}}};
      flags_res = 4'b0000;
    end else if (e_pre <= E_ZERO) begin
      m_res     = {sign, {(W-1){1'b0}}};
      flags_res = 4'b0011;
    end else if (e_rnd >= E_MAX) begin
      m_res     = rm_q ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}}
                       : {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_res = 4'b0101;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    rm_d        = rm_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    m_d         = m_q;
    flags_d     = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          rm_d       = bus.rm;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_MUL;
        end
      end
      S_MUL: begin
        if (sig_b[cnt_q]) acc_d = acc_q + (ACC_W'(sig_a) << cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_NORM;
      end
      S_NORM: begin
        m_d         = m_res;
        flags_d     = flags_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rm_q        <= rm_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      m_q         <= m_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.m         = m_q;
  assign bus.flags     = flags_q;
  assign state_dbg     = state_q;

endmodule
